load_align_unit: RTL and testbench
==================================

# load_align_unit

Parametrised load-path unit between the MEM stage and the data-memory port. It accepts one load request at a time and issues aligned bus reads, up to two per load. It extracts and sign/zero-extends the addressed bytes and returns a registered result to writeback. Unlike the single-cycle W-stage extractor it replaces, it supports a 64-bit datapath, a memory handshake, and either AdEL trapping or split-and-merge of misaligned loads.

## Interface
- DATA_W, 32: datapath/bus width, 32 or 64; LANES = DATA_W/8.
- SPLIT_MISALIGNED, 0: 0 = misaligned load reports AdEL; 1 = misaligned load split into two aligned reads and merged.
- clk  in  1  core clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; aborts the current load.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  3  LD_B, LD_BU, LD_H, LD_HU, LD_W, LD_WU, LD_D.
- req_addr  in  32  byte virtual address.
- mem_req  out  1  bus read request.
- mem_addr  out  32  aligned bus address, low log2(LANES) bits zero.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; exactly one per granted request, in order.
- mem_rdata  in  DATA_W  read data, little-endian lanes.
- resp_valid  out  1  result valid.
- resp_ready  in  1  writeback accepts the result.
- resp_data  out  DATA_W  extended load result.
- resp_adel  out  1  address-error exception.
- resp_badvaddr  out  32  faulting address, valid with resp_adel.

## Operation
- Access size S: B/BU=1, H/HU=2, W/WU=4, D=8.
- LD_WU and LD_D are illegal when DATA_W=32 and respond with resp_adel=1.
- Offset o = req_addr mod LANES. A load is misaligned when req_addr mod S != 0.
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP, DRAIN.
- IDLE: req_ready=1. On accept, latch op, addr and o:
  - Illegal op, or misaligned with SPLIT_MISALIGNED=0 -> RESP with resp_adel=1, resp_badvaddr=req_addr, resp_data=0, no bus access.
  - Otherwise -> REQ1.
- REQ1: mem_req=1, mem_addr = addr with low bits cleared. On mem_gnt -> WAIT1.
- WAIT1: on mem_rvalid, capture the data.
  - If o+S <= LANES -> RESP.
  - Else (split) -> REQ2.
- REQ2: mem_addr = first address + LANES. On mem_gnt -> WAIT2.
- WAIT2: on mem_rvalid -> RESP.
- Byte extraction:
  - Non-split: bytes o..o+S-1 of the first read.
  - Split: bytes o..LANES-1 of the first read form the low part; bytes 0..o+S-LANES-1 of the second read form the high part.
- Extension: B/H/W sign-extend from bit 8S-1; BU/HU/WU zero-extend; D is passed through.
- RESP: resp_valid=1. Outputs hold stable until resp_ready, then -> IDLE.
- flush:
  - In IDLE or RESP: go to IDLE. resp_valid drops next cycle; a pending response is discarded.
  - In REQ1/REQ2 before grant: drop mem_req, go to IDLE.
  - In WAIT1/WAIT2 (read outstanding): go to DRAIN, consume the next mem_rvalid, then IDLE. No resp_valid. A grant in the flush cycle of REQx also counts as outstanding.
- An address wrap from 0xFFFF_FFFx into the second read wraps mod 2^32; no error.

## Timing
- Reset values: state=IDLE, req_ready=1, mem_req=0, mem_addr=0, resp_valid=0, resp_data=0, resp_adel=0, resp_badvaddr=0.
- All outputs are registered, except req_ready, which is decoded from state.
- Aligned load latency: accept at cycle 0; mem_req at cycle 1; with grant at cycle 1 and rvalid at cycle 2, resp_valid at cycle 3.
- Split load adds 2 cycles minimum (REQ2 + WAIT2).
- AdEL response: resp_valid in the cycle after accept.
- resp_valid with resp_ready=1 can complete in the same cycle. A new request is accepted at the earliest one cycle later, with no IDLE/RESP overlap.
- mem_req and mem_addr hold stable until mem_gnt.
- resetn mid-operation: immediate return to reset values. The bus side treats the outstanding read as abandoned.

## Structure
- Shared package `lsu_pkg`: load-op encodings (LD_B=0 … LD_D=6), the FSM state enum, and the size(op) / signed(op) helper functions.
- One sub-module, `load_extract`: combinational byte select, merge and extend. Inputs: two DATA_W words, o, op, split flag.

## Test plan
- DATA_W=32, LD_B at 0x1003, mem_rdata=0x80AA_BBCC -> resp_data=0xFFFF_FF80, latency 3 with immediate grant/rvalid.
- DATA_W=32, LD_HU at 0x1001, SPLIT=0 -> resp_adel=1, resp_badvaddr=0x1001, no mem_req, resp_valid one cycle after accept.
- DATA_W=32, SPLIT=1, LD_W at 0x1002, reads 0x1000 -> 0x4433_2211 and 0x1004 -> 0x8877_6655 -> resp_data=0x6655_4433, two mem_req with addresses 0x1000 then 0x1004.
- DATA_W=64, LD_WU at 0x2004, mem_rdata=0x8765_4321_0000_0000 -> resp_data=0x0000_0000_8765_4321; LD_D at 0x2000 passes through.
- flush in WAIT1 with rvalid delayed 3 cycles -> no resp_valid, req_ready low until the rvalid is drained; the next load then completes normally.
- resp_ready held low 4 cycles -> resp_data/resp_valid stable; mem_gnt stalled 5 cycles -> mem_req/mem_addr stable; resetn pulse mid-WAIT2 -> all outputs return to reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load-path definitions: op encodings, FSM states and op decode helpers.
package lsu_pkg;

   typedef enum logic [2:0] {
      LD_B  = 3'd0,
      LD_BU = 3'd1,
      LD_H  = 3'd2,
      LD_HU = 3'd3,
      LD_W  = 3'd4,
      LD_WU = 3'd5,
      LD_D  = 3'd6
   } load_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ1,
      S_WAIT1,
      S_REQ2,
      S_WAIT2,
      S_RESP,
      S_DRAIN
   } state_e;

   // Access size in bytes
   function automatic logic [3:0] op_size(input load_op_e op);
      case (op)
         LD_B, LD_BU: op_size = 4'd1;
         LD_H, LD_HU: op_size = 4'd2;
         LD_W, LD_WU: op_size = 4'd4;
         default:     op_size = 4'd8;
      endcase
   endfunction

   function automatic logic op_signed(input load_op_e op);
      op_signed = (op == LD_B) || (op == LD_H) || (op == LD_W);
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational byte select, split merge and sign/zero extension of load data.
module load_extract
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0] word0,
   input  logic [DATA_W-1:0] word1,
   input  logic [OFF_W-1:0]  off,
   input  load_op_e          op,
   input  logic              split,
   output logic [DATA_W-1:0] data
);

   localparam int unsigned IDX_W = $clog2(DATA_W);

   logic [2*DATA_W-1:0] pair;
   logic [DATA_W-1:0]   raw;
   logic [IDX_W-1:0]    top;
   logic                fill;

   // Second word supplies the high bytes only for split loads
   always_comb begin
      pair = {(split ? word1 : {DATA_W{1'b0}}), word0};
      raw  = DATA_W'(pair >> {off, 3'b000});
      case (op_size(op))
         4'd1:    top = IDX_W'(7);
         4'd2:    top = IDX_W'(15);
         4'd4:    top = IDX_W'(31);
         default: top = IDX_W'(DATA_W - 1);
      endcase
      fill = op_signed(op) & raw[top];
      data = raw;
      for (int unsigned i = 0; i < DATA_W; i++) begin
         if (i > 32'(top)) data[i] = fill;
      end
   end

endmodule

// File: rtl/load_align_unit.sv
// Load path between MEM and the data bus: aligned reads, optional split/merge, AdEL trapping.
module load_align_unit
   import lsu_pkg::*;
#(
   parameter int unsigned DATA_W           = 32,
   parameter bit          SPLIT_MISALIGNED = 1'b0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              flush,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_op,
   input  logic [31:0]       req_addr,
   output logic              mem_req,
   output logic [31:0]       mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_data,
   output logic              resp_adel,
   output logic [31:0]       resp_badvaddr
);

   localparam int unsigned LANES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(LANES);

   state_e            state;
   load_op_e          op_q;
   logic [OFF_W-1:0]  off_q;
   logic              split_q;
   logic [DATA_W-1:0] first_q;

   load_op_e          req_op_e;
   logic [3:0]        req_size;
   logic [OFF_W-1:0]  req_off;
   logic              op_legal;
   logic              misaligned;
   logic              req_split;
   logic              req_fault;
   logic [DATA_W-1:0] ext_word0;
   logic [DATA_W-1:0] ext_data;

   assign req_ready = (state == S_IDLE);

   // Request decode
   always_comb begin
      req_op_e   = load_op_e'(req_op);
      req_size   = op_size(req_op_e);
      req_off    = req_addr[OFF_W-1:0];
      op_legal   = (req_op <= 3'd6) &&
                   !((DATA_W == 32) && ((req_op_e == LD_WU) || (req_op_e == LD_D)));
      misaligned = (req_addr[3:0] & (req_size - 4'd1)) != 4'd0;
      req_split  = (32'(req_off) + 32'(req_size)) > LANES;
      req_fault  = !op_legal || (misaligned && !SPLIT_MISALIGNED);
   end

   // Non-split results come straight from the bus; split results merge with the held first word
   assign ext_word0 = (state == S_WAIT1) ? mem_rdata : first_q;

   load_extract #(
      .DATA_W (DATA_W),
      .OFF_W  (OFF_W)
   ) u_extract (
      .word0 (ext_word0),
      .word1 (mem_rdata),
      .off   (off_q),
      .op    (op_q),
      .split (state == S_WAIT2),
      .data  (ext_data)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= S_IDLE;
         op_q          <= LD_B;
         off_q         <= '0;
         split_q       <= 1'b0;
         first_q       <= '0;
         mem_req       <= 1'b0;
         mem_addr      <= '0;
         resp_valid    <= 1'b0;
         resp_data     <= '0;
         resp_adel     <= 1'b0;
         resp_badvaddr <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && !flush) begin
                  op_q    <= req_op_e;
                  off_q   <= req_off;
                  split_q <= req_split;
                  if (req_fault) begin
                     state         <= S_RESP;
                     resp_valid    <= 1'b1;
                     resp_adel     <= 1'b1;
                     resp_badvaddr <= req_addr;
                     resp_data     <= '0;
                  end else begin
                     state    <= S_REQ1;
                     mem_req  <= 1'b1;
                     mem_addr <= {req_addr[31:OFF_W], OFF_W'(0)};
                  end
               end
            end
            S_REQ1, S_REQ2: begin
               // A grant coinciding with flush still leaves a read to drain
               if (flush) begin
                  mem_req <= 1'b0;
                  state   <= mem_gnt ? S_DRAIN : S_IDLE;
               end else if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= (state == S_REQ1) ? S_WAIT1 : S_WAIT2;
               end
            end
            S_WAIT1, S_WAIT2: begin
               if (flush) begin
                  state <= mem_rvalid ? S_IDLE : S_DRAIN;
               end else if (mem_rvalid) begin
                  if ((state == S_WAIT1) && split_q) begin
                     first_q  <= mem_rdata;
                     state    <= S_REQ2;
                     mem_req  <= 1'b1;
                     mem_addr <= mem_addr + 32'(LANES);
                  end else begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_adel  <= 1'b0;
                     resp_data  <= ext_data;
                  end
               end
            end
            S_RESP: begin
               if (flush || resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            S_DRAIN: begin
               if (mem_rvalid) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench: 32-bit trap variant (a), 32-bit split variant (b), 64-bit split variant (c).
module tb_load_align_unit;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        resetn;
   logic        flush;
   logic [2:0]  req_op;
   logic [31:0] req_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [63:0] mem_rdata;
   logic        resp_ready;

   logic        req_valid_a, req_ready_a, mem_req_a, resp_valid_a, resp_adel_a;
   logic [31:0] mem_addr_a, resp_data_a, resp_badvaddr_a;
   logic        req_valid_b, req_ready_b, mem_req_b, resp_valid_b, resp_adel_b;
   logic [31:0] mem_addr_b, resp_data_b, resp_badvaddr_b;
   logic        req_valid_c, req_ready_c, mem_req_c, resp_valid_c, resp_adel_c;
   logic [31:0] mem_addr_c, resp_badvaddr_c;
   logic [63:0] resp_data_c;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   load_align_unit #(.DATA_W(32), .SPLIT_MISALIGNED(1'b0)) u_a (
      .clk(clk), .resetn(resetn), .flush(flush),
      .req_valid(req_valid_a), .req_ready(req_ready_a), .req_op(req_op), .req_addr(req_addr),
      .mem_req(mem_req_a), .mem_addr(mem_addr_a), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
      .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_data(resp_data_a),
      .resp_adel(resp_adel_a), .resp_badvaddr(resp_badvaddr_a)
   );

   load_align_unit #(.DATA_W(32), .SPLIT_MISALIGNED(1'b1)) u_b (
      .clk(clk), .resetn(resetn), .flush(flush),
      .req_valid(req_valid_b), .req_ready(req_ready_b), .req_op(req_op), .req_addr(req_addr),
      .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0]),
      .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_data(resp_data_b),
      .resp_adel(resp_adel_b), .resp_badvaddr(resp_badvaddr_b)
   );

   load_align_unit #(.DATA_W(64), .SPLIT_MISALIGNED(1'b1)) u_c (
      .clk(clk), .resetn(resetn), .flush(flush),
      .req_valid(req_valid_c), .req_ready(req_ready_c), .req_op(req_op), .req_addr(req_addr),
      .mem_req(mem_req_c), .mem_addr(mem_addr_c), .mem_gnt(mem_gnt),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid_c), .resp_ready(resp_ready), .resp_data(resp_data_c),
      .resp_adel(resp_adel_c), .resp_badvaddr(resp_badvaddr_c)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Aligned load on instance a with immediate grant and rvalid
   task automatic run_a(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] rd, input logic [31:0] exp_addr,
                        input logic [31:0] exp_data);
      req_valid_a = 1'b1; req_op = op; req_addr = addr; mem_gnt = 1'b1; resp_ready = 1'b1;
      step(); req_valid_a = 1'b0;
      chk({tag, ".mem_req"}, 64'(mem_req_a), 64'd1);
      chk({tag, ".mem_addr"}, 64'(mem_addr_a), 64'(exp_addr));
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'(rd);
      chk({tag, ".early_valid"}, 64'(resp_valid_a), 64'd0);
      step(); mem_rvalid = 1'b0;
      chk({tag, ".valid"}, 64'(resp_valid_a), 64'd1);
      chk({tag, ".data"}, 64'(resp_data_a), 64'(exp_data));
      chk({tag, ".adel"}, 64'(resp_adel_a), 64'd0);
      step();
      chk({tag, ".done"}, 64'(resp_valid_a), 64'd0);
   endtask

   // Aligned load on instance c with immediate grant and rvalid
   task automatic run_c(input string tag, input logic [2:0] op, input logic [31:0] addr,
                        input logic [63:0] rd, input logic [31:0] exp_addr,
                        input logic [63:0] exp_data);
      req_valid_c = 1'b1; req_op = op; req_addr = addr; mem_gnt = 1'b1; resp_ready = 1'b1;
      step(); req_valid_c = 1'b0;
      chk({tag, ".mem_addr"}, 64'(mem_addr_c), 64'(exp_addr));
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rd;
      step(); mem_rvalid = 1'b0;
      chk({tag, ".valid"}, 64'(resp_valid_c), 64'd1);
      chk({tag, ".data"}, resp_data_c, exp_data);
      chk({tag, ".adel"}, 64'(resp_adel_c), 64'd0);
      step();
      chk({tag, ".ready"}, 64'(req_ready_c), 64'd1);
   endtask

   // Split load on instance b: two grants, two reads
   task automatic run_b_split(input string tag, input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] a1, input logic [31:0] a2,
                              input logic [31:0] exp_data);
      req_valid_b = 1'b1; req_op = op; req_addr = addr; mem_gnt = 1'b1; resp_ready = 1'b1;
      step(); req_valid_b = 1'b0;
      chk({tag, ".req1"}, 64'(mem_req_b), 64'd1);
      chk({tag, ".addr1"}, 64'(mem_addr_b), 64'(a1));
      step(); mem_rvalid = 1'b1; mem_rdata = 64'(rd1);
      chk({tag, ".req_drop"}, 64'(mem_req_b), 64'd0);
      step(); mem_rvalid = 1'b0;
      chk({tag, ".req2"}, 64'(mem_req_b), 64'd1);
      chk({tag, ".addr2"}, 64'(mem_addr_b), 64'(a2));
      step(); mem_rvalid = 1'b1; mem_rdata = 64'(rd2);
      chk({tag, ".early_valid"}, 64'(resp_valid_b), 64'd0);
      step(); mem_rvalid = 1'b0; mem_gnt = 1'b0;
      chk({tag, ".valid"}, 64'(resp_valid_b), 64'd1);
      chk({tag, ".data"}, 64'(resp_data_b), 64'(exp_data));
      step();
      chk({tag, ".done"}, 64'(resp_valid_b), 64'd0);
   endtask

   initial begin
      resetn = 1'b0; flush = 1'b0; req_op = 3'd0; req_addr = '0;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; resp_ready = 1'b1;
      req_valid_a = 1'b0; req_valid_b = 1'b0; req_valid_c = 1'b0;
      step(); step();
      chk("rst.req_ready", 64'(req_ready_a), 64'd1);
      chk("rst.mem_req", 64'(mem_req_a), 64'd0);
      chk("rst.mem_addr", 64'(mem_addr_a), 64'd0);
      chk("rst.resp_valid", 64'(resp_valid_a), 64'd0);
      chk("rst.resp_data", 64'(resp_data_a), 64'd0);
      chk("rst.resp_adel", 64'(resp_adel_a), 64'd0);
      chk("rst.badvaddr", 64'(resp_badvaddr_a), 64'd0);
      resetn = 1'b1;
      step();

      // Signed byte at the top lane, 3-cycle latency
      run_a("ldb", 3'(LD_B), 32'h0000_1003, 32'h80AA_BBCC, 32'h0000_1000, 32'hFFFF_FF80);

      // Misaligned halfword traps without touching the bus
      req_valid_a = 1'b1; req_op = 3'(LD_HU); req_addr = 32'h0000_1001;
      step(); req_valid_a = 1'b0;
      chk("adel_hu.valid", 64'(resp_valid_a), 64'd1);
      chk("adel_hu.adel", 64'(resp_adel_a), 64'd1);
      chk("adel_hu.badvaddr", 64'(resp_badvaddr_a), 64'h1001);
      chk("adel_hu.data", 64'(resp_data_a), 64'd0);
      chk("adel_hu.mem_req", 64'(mem_req_a), 64'd0);
      step();
      chk("adel_hu.done", 64'(resp_valid_a), 64'd0);

      // Doubleword is illegal on a 32-bit datapath even when aligned
      req_valid_a = 1'b1; req_op = 3'(LD_D); req_addr = 32'h0000_1000;
      step(); req_valid_a = 1'b0;
      chk("adel_d.adel", 64'(resp_adel_a), 64'd1);
      chk("adel_d.badvaddr", 64'(resp_badvaddr_a), 64'h1000);
      chk("adel_d.mem_req", 64'(mem_req_a), 64'd0);
      step();

      // Grant stalled 5 cycles, then response back-pressured 4 cycles
      req_valid_a = 1'b1; req_op = 3'(LD_H); req_addr = 32'h0000_1002; mem_gnt = 1'b0;
      step(); req_valid_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall.mem_req", 64'(mem_req_a), 64'd1);
         chk("stall.mem_addr", 64'(mem_addr_a), 64'h1000);
         step();
      end
      mem_gnt = 1'b1;
      chk("stall.mem_req_last", 64'(mem_req_a), 64'd1);
      step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_BEEF_1234;
      step(); mem_rvalid = 1'b0; resp_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("bp.valid", 64'(resp_valid_a), 64'd1);
         chk("bp.data", 64'(resp_data_a), 64'hFFFF_BEEF);
         step();
      end
      resp_ready = 1'b1;
      chk("bp.valid_last", 64'(resp_valid_a), 64'd1);
      step();
      chk("bp.done", 64'(resp_valid_a), 64'd0);

      // Flush with a read outstanding: drain it, no response
      req_valid_a = 1'b1; req_op = 3'(LD_W); req_addr = 32'h0000_1000; mem_gnt = 1'b1;
      step(); req_valid_a = 1'b0;
      step(); mem_gnt = 1'b0; flush = 1'b1;
      step(); flush = 1'b0;
      chk("flush.ready0", 64'(req_ready_a), 64'd0);
      step();
      chk("flush.ready1", 64'(req_ready_a), 64'd0);
      mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_DEAD_BEEF;
      step(); mem_rvalid = 1'b0;
      chk("flush.no_resp", 64'(resp_valid_a), 64'd0);
      chk("flush.ready2", 64'(req_ready_a), 64'd1);
      run_a("post_flush", 3'(LD_BU), 32'h0000_1001, 32'h0000_9900, 32'h0000_1000, 32'h0000_0099);

      // 64-bit datapath
      run_c("wu64", 3'(LD_WU), 32'h0000_2004, 64'h8765_4321_0000_0000,
            32'h0000_2000, 64'h0000_0000_8765_4321);
      run_c("d64", 3'(LD_D), 32'h0000_2000, 64'h0123_4567_89AB_CDEF,
            32'h0000_2000, 64'h0123_4567_89AB_CDEF);
      run_c("b64", 3'(LD_B), 32'h0000_2007, 64'h7F00_0000_0000_0000,
            32'h0000_2000, 64'h0000_0000_0000_007F);
      chk("c.badvaddr", 64'(resp_badvaddr_c), 64'd0);

      // Split variant: illegal op still traps
      req_valid_b = 1'b1; req_op = 3'(LD_WU); req_addr = 32'h0000_1004;
      step(); req_valid_b = 1'b0;
      chk("b_adel.adel", 64'(resp_adel_b), 64'd1);
      chk("b_adel.badvaddr", 64'(resp_badvaddr_b), 64'h1004);
      step();

      run_b_split("split_w", 3'(LD_W), 32'h0000_1002, 32'h4433_2211, 32'h8877_6655,
                  32'h0000_1000, 32'h0000_1004, 32'h6655_4433);
      run_b_split("wrap_h", 3'(LD_H), 32'hFFFF_FFFF, 32'hAB00_0000, 32'h0000_00CD,
                  32'hFFFF_FFFC, 32'h0000_0000, 32'hFFFF_CDAB);

      // Reset pulse while the second read is outstanding
      req_valid_b = 1'b1; req_op = 3'(LD_W); req_addr = 32'h0000_1002; mem_gnt = 1'b1;
      step(); req_valid_b = 1'b0;
      step(); mem_rvalid = 1'b1; mem_rdata = 64'h0000_0000_4433_2211;
      step(); mem_rvalid = 1'b0;
      step(); mem_gnt = 1'b0;
      chk("rst2.pre_ready", 64'(req_ready_b), 64'd0);
      resetn = 1'b0;
      #1;
      chk("rst2.req_ready", 64'(req_ready_b), 64'd1);
      chk("rst2.mem_req", 64'(mem_req_b), 64'd0);
      chk("rst2.mem_addr", 64'(mem_addr_b), 64'd0);
      chk("rst2.resp_valid", 64'(resp_valid_b), 64'd0);
      chk("rst2.resp_data", 64'(resp_data_b), 64'd0);
      chk("rst2.resp_adel", 64'(resp_adel_b), 64'd0);
      chk("rst2.badvaddr", 64'(resp_badvaddr_b), 64'd0);
      step(); resetn = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
